// File: rtl/ghost_mode_scheduler_pkg.sv
// rtl/ghost_mode_scheduler_pkg.sv - shared AI state codes, schedule defaults and ghost state type
package ghost_mode_scheduler_pkg;

    localparam logic [3:0] AI_SCATTER    = 4'd0;
    localparam logic [3:0] AI_CHASE      = 4'd1;
    localparam logic [3:0] AI_FRIGHTENED = 4'd2;
    localparam logic [3:0] AI_DEAD       = 4'b1011;

    localparam int FRAME_RATE_DEFAULT = 30;

    // Phase 0 sits in the low byte; a zero length never expires.
    localparam logic [63:0] SCHED_DEFAULT = {8'd0, 8'd5, 8'd20, 8'd5, 8'd20, 8'd7, 8'd20, 8'd7};

    typedef enum logic [1:0] {
        GS_NORMAL,
        GS_FRIGHT,
        GS_DEAD
    } ghost_state_t;

    function automatic logic [3:0] ai_code(input ghost_state_t st, input logic chase);
        logic [3:0] code;
        case (st)
            GS_FRIGHT: code = AI_FRIGHTENED;
            GS_DEAD:   code = AI_DEAD;
            default:   code = chase ? AI_CHASE : AI_SCATTER;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_mode_phase_timer.sv
// rtl/ghost_mode_scheduler_mode_phase_timer.sv - frame-tick to seconds divider and scatter/chase phase sequencer
module mode_phase_timer
    import ghost_mode_scheduler_pkg::*;
#(
    parameter int          FRAME_RATE = FRAME_RATE_DEFAULT,
    parameter logic [63:0] SCHED      = SCHED_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_start,
    input  logic ce,
    input  logic freeze,
    output logic chase,
    output logic phase_switch
);

    localparam int DW = $clog2(FRAME_RATE > 1 ? FRAME_RATE : 2);
    localparam logic [DW-1:0] DIV_MAX = DW'(FRAME_RATE - 1);

    logic [DW-1:0] div_q, div_d;
    logic [7:0]    sec_q, sec_d;
    logic [2:0]    phase_q, phase_d;
    logic [7:0]    len;

    always_comb begin
        div_d        = div_q;
        sec_d        = sec_q;
        phase_d      = phase_q;
        phase_switch = 1'b0;
        len          = SCHED[{phase_q, 3'b000} +: 8];
        if (level_start) begin
            div_d   = '0;
            sec_d   = '0;
            phase_d = '0;
        end else if (ce && !freeze) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                // Phase 7 and zero-length phases hold forever; seconds just wrap.
                if (len != 8'd0 && phase_q != 3'd7 && 8'(sec_q + 8'd1) == len) begin
                    sec_d        = '0;
                    phase_d      = phase_q + 3'd1;
                    phase_switch = 1'b1;
                end else begin
                    sec_d = sec_q + 8'd1;
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            sec_q   <= '0;
            phase_q <= '0;
        end else begin
            div_q   <= div_d;
            sec_q   <= sec_d;
            phase_q <= phase_d;
        end
    end

    assign chase = phase_q[0];

endmodule

// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - per-ghost AI mode sequencer: schedule, fright, death and return home
module ghost_mode_scheduler
    import ghost_mode_scheduler_pkg::*;
#(
    parameter int          FRAME_RATE  = FRAME_RATE_DEFAULT,
    parameter int          FRIGHT_TIME = 48,
    parameter logic [63:0] SCHED       = SCHED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        level_start,
    input  logic        power_pellet,
    input  logic [3:0]  ghost_eaten,
    input  logic [3:0]  ghost_home,
    output logic [15:0] ai_state,
    output logic [5:0]  ai_timer,
    output logic        fright_active,
    output logic [1:0]  eat_count,
    output logic [3:0]  reverse
);

    localparam logic [5:0] T_LAST = 6'(FRIGHT_TIME - 1);

    ghost_state_t st_q [4];
    ghost_state_t st_d [4];
    logic [5:0]   timer_q, timer_d;
    logic         fa_q, fa_d;
    logic [1:0]   ec_q, ec_d;
    logic [3:0]   rev_q, rev_d;
    logic [2:0]   n_eaten;
    logic [2:0]   ec_sum;
    logic         chase;
    logic         phase_switch;

    mode_phase_timer #(
        .FRAME_RATE (FRAME_RATE),
        .SCHED      (SCHED)
    ) u_phase (
        .clk          (clk),
        .rst_n        (rst_n),
        .level_start  (level_start),
        .ce           (ce),
        .freeze       (fa_q | power_pellet),
        .chase        (chase),
        .phase_switch (phase_switch)
    );

    always_comb begin
        for (int n = 0; n < 4; n++) st_d[n] = st_q[n];
        timer_d = timer_q;
        fa_d    = fa_q;
        rev_d   = '0;
        n_eaten = '0;
        // Eaten and home both look at the state held at the start of the cycle.
        for (int n = 0; n < 4; n++) begin
            if (ghost_eaten[n] && st_q[n] == GS_FRIGHT) begin
                st_d[n] = GS_DEAD;
                n_eaten = n_eaten + 3'd1;
            end else if (ghost_home[n] && st_q[n] == GS_DEAD) begin
                st_d[n] = GS_NORMAL;
            end
        end
        ec_sum = {1'b0, ec_q} + n_eaten;
        ec_d   = (ec_sum > 3'd3) ? 2'd3 : ec_sum[1:0];
        if (power_pellet) begin
            fa_d    = 1'b1;
            timer_d = '0;
            ec_d    = '0;
            for (int n = 0; n < 4; n++) begin
                if (st_d[n] != GS_DEAD) begin
                    st_d[n]  = GS_FRIGHT;
                    rev_d[n] = 1'b1;
                end
            end
        end else if (fa_q && ce) begin
            if (timer_q == T_LAST) begin
                fa_d    = 1'b0;
                timer_d = '0;
                for (int n = 0; n < 4; n++)
                    if (st_d[n] == GS_FRIGHT) st_d[n] = GS_NORMAL;
            end else begin
                timer_d = timer_q + 6'd1;
            end
        end
        if (phase_switch) begin
            for (int n = 0; n < 4; n++)
                if (st_q[n] == GS_NORMAL) rev_d[n] = 1'b1;
        end
        if (level_start) begin
            for (int n = 0; n < 4; n++) st_d[n] = GS_NORMAL;
            timer_d = '0;
            fa_d    = 1'b0;
            ec_d    = '0;
            rev_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) st_q[n] <= GS_NORMAL;
            timer_q <= '0;
            fa_q    <= 1'b0;
            ec_q    <= '0;
            rev_q   <= '0;
        end else begin
            for (int n = 0; n < 4; n++) st_q[n] <= st_d[n];
            timer_q <= timer_d;
            fa_q    <= fa_d;
            ec_q    <= ec_d;
            rev_q   <= rev_d;
        end
    end

    always_comb begin
        ai_state = '0;
        for (int n = 0; n < 4; n++) ai_state[4*n +: 4] = ai_code(st_q[n], chase);
    end

    assign ai_timer      = timer_q;
    assign fright_active = fa_q;
    assign eat_count     = ec_q;
    assign reverse       = rev_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb/tb_ghost_mode_scheduler.sv - randomized and directed self-checking bench for ghost_mode_scheduler
module tb_ghost_mode_scheduler;

    localparam int FR = 2;
    localparam int FT = 48;
    localparam int SCHED_S [8] = '{7, 20, 7, 20, 5, 20, 5, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        level_start = 1'b0;
    logic        power_pellet = 1'b0;
    logic [3:0]  ghost_eaten = '0;
    logic [3:0]  ghost_home = '0;
    logic [15:0] ai_state;
    logic [5:0]  ai_timer;
    logic        fright_active;
    logic [1:0]  eat_count;
    logic [3:0]  reverse;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: ghost kind 0 = follows schedule, 1 = frightened, 2 = dead.
    int       m_phase, m_ticks, m_timer, m_ec;
    bit       m_fa;
    int       m_kind [4];
    logic [3:0] m_rev;

    ghost_mode_scheduler #(.FRAME_RATE(FR), .FRIGHT_TIME(FT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .level_start   (level_start),
        .power_pellet  (power_pellet),
        .ghost_eaten   (ghost_eaten),
        .ghost_home    (ghost_home),
        .ai_state      (ai_state),
        .ai_timer      (ai_timer),
        .fright_active (fright_active),
        .eat_count     (eat_count),
        .reverse       (reverse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_ai_state();
        logic [15:0] v = '0;
        for (int n = 0; n < 4; n++) begin
            if (m_kind[n] == 1)      v[4*n +: 4] = 4'd2;
            else if (m_kind[n] == 2) v[4*n +: 4] = 4'hB;
            else                     v[4*n +: 4] = (m_phase % 2 == 1) ? 4'd1 : 4'd0;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_timer = 0; m_ec = 0; m_fa = 0; m_rev = '0;
        for (int n = 0; n < 4; n++) m_kind[n] = 0;
    endtask

    task automatic model_step(input bit c, input bit ls, input bit pp,
                              input logic [3:0] ge, input logic [3:0] gh);
        int  old_kind [4];
        bit  old_fa;
        int  ne;
        if (ls) begin
            model_reset();
            return;
        end
        old_kind = m_kind;
        old_fa   = m_fa;
        m_rev    = '0;
        ne       = 0;
        for (int n = 0; n < 4; n++) begin
            if (ge[n] && old_kind[n] == 1) begin m_kind[n] = 2; ne++; end
            if (gh[n] && old_kind[n] == 2) m_kind[n] = 0;
        end
        m_ec = (m_ec + ne > 3) ? 3 : m_ec + ne;
        if (pp) begin
            m_fa = 1; m_timer = 0; m_ec = 0;
            for (int n = 0; n < 4; n++)
                if (m_kind[n] != 2) begin m_kind[n] = 1; m_rev[n] = 1'b1; end
        end else if (m_fa && c) begin
            if (m_timer == FT - 1) begin
                m_fa = 0; m_timer = 0;
                for (int n = 0; n < 4; n++) if (m_kind[n] == 1) m_kind[n] = 0;
            end else begin
                m_timer++;
            end
        end
        if (c && !old_fa && !pp) begin
            m_ticks++;
            if (m_phase != 7 && SCHED_S[m_phase] != 0 && m_ticks == SCHED_S[m_phase] * FR) begin
                m_phase++;
                m_ticks = 0;
                for (int n = 0; n < 4; n++) if (old_kind[n] == 0) m_rev[n] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input bit c, input bit ls, input bit pp,
                        input logic [3:0] ge, input logic [3:0] gh);
        ce = c; level_start = ls; power_pellet = pp; ghost_eaten = ge; ghost_home = gh;
        @(posedge clk);
        model_step(c, ls, pp, ge, gh);
        #1;
        ce = 1'b0; level_start = 1'b0; power_pellet = 1'b0; ghost_eaten = '0; ghost_home = '0;
    endtask

    task automatic run_ce(input int k);
        for (int i = 0; i < k; i++) begin
            if (i > 0) repeat (3) tick(0, 0, 0, 4'h0, 4'h0);
            tick(1, 0, 0, 4'h0, 4'h0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ai_state"}, 32'(ai_state), 32'h0);
        check({tag, "_ai_timer"}, 32'(ai_timer), 32'h0);
        check({tag, "_fright"},   32'(fright_active), 32'h0);
        check({tag, "_eat"},      32'(eat_count), 32'h0);
        check({tag, "_reverse"},  32'(reverse), 32'h0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_cmp++;
                if (ai_state !== exp_ai_state() || ai_timer !== 6'(m_timer) ||
                    fright_active !== m_fa || eat_count !== 2'(m_ec) || reverse !== m_rev) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t ai_state %h/%h ai_timer %0d/%0d fright %0b/%0b eat %0d/%0d reverse %h/%h (got/exp)",
                             $time, ai_state, exp_ai_state(), ai_timer, m_timer, fright_active, m_fa,
                             eat_count, m_ec, reverse, m_rev);
                end
            end
        end
    end

    initial begin
        model_reset();
        #2;
        check_all_zero("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        run_ce(14);
        check("sched_first_switch_state", 32'(ai_state), 32'h1111);
        check("sched_first_switch_rev",   32'(reverse),  32'hF);
        run_ce(40);
        check("sched_back_to_scatter",    32'(ai_state), 32'h0000);
        check("sched_back_rev",           32'(reverse),  32'hF);
        run_ce(14);
        check("sched_chase2",             32'(ai_state), 32'h1111);

        tick(0, 0, 1, 4'h0, 4'h0);
        check("fright_state", 32'(ai_state), 32'h2222);
        check("fright_rev",   32'(reverse),  32'hF);
        check("fright_active", 32'(fright_active), 32'h1);
        run_ce(48);
        check("fright_end_state", 32'(ai_state), 32'h1111);
        check("fright_end_timer", 32'(ai_timer), 32'h0);
        check("fright_end_active", 32'(fright_active), 32'h0);
        run_ce(40);
        check("phase_frozen_in_fright", 32'(ai_state), 32'h0000);
        check("phase_frozen_rev",       32'(reverse),  32'hF);

        tick(0, 0, 1, 4'h0, 4'h0);
        tick(0, 0, 0, 4'b0001, 4'h0);
        tick(0, 0, 0, 4'b0100, 4'h0);
        tick(0, 0, 0, 4'b0001, 4'h0);
        check("eat_chain_state", 32'(ai_state), 32'h2B2B);
        check("eat_chain_count", 32'(eat_count), 32'h2);
        tick(0, 0, 0, 4'h0, 4'b0001);
        check("home_state",  32'(ai_state), 32'h2B20);
        check("home_fright", 32'(fright_active), 32'h1);

        run_ce(3);
        tick(0, 0, 1, 4'b0010, 4'h0);
        check("simul_state", 32'(ai_state), 32'h2BB2);
        check("simul_eat",   32'(eat_count), 32'h0);
        check("simul_timer", 32'(ai_timer), 32'h0);
        check("simul_rev",   32'(reverse), 32'h9);

        rst_n = 1'b0;
        #2;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        tick(0, 0, 1, 4'h0, 4'h0);
        run_ce(3);
        tick(0, 1, 0, 4'h0, 4'h0);
        check_all_zero("level_start");

        run_ce(168);
        check("phase7_state", 32'(ai_state), 32'h1111);
        check("phase7_rev",   32'(reverse),  32'hF);
        run_ce(200);
        check("phase7_hold",  32'(ai_state), 32'h1111);

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(2) == 0, $urandom_range(999) == 0, $urandom_range(149) == 0,
                 ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0,
                 ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
